// File: rtl/vsd_bus_master.sv
// VSD peripheral bus initiator: runs write/read/poll commands one at a time on the
// single-cycle sel/we/addr bus and returns results on a valid/ready response port.
module vsd_bus_master #(
    parameter int RD_LATENCY = 0,
    parameter int POLL_MAX   = 16,
    parameter int POLL_GAP   = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        sel,
    output logic        we,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_RD       = 3'd2,
        ST_POLL_GAP = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    localparam logic [15:0] POLL_MAX_C = 16'(POLL_MAX);
    localparam logic [7:0]  GAP_LAST_C = (POLL_GAP > 0) ? 8'(POLL_GAP - 1) : 8'd0;

    state_t      state_r;
    logic        is_poll_r;
    logic [31:0] addr_hold_r;
    logic [31:0] data_hold_r;
    logic [15:0] poll_cnt_r;
    logic [7:0]  gap_cnt_r;
    logic        lat_cnt_r;
    logic        sel_r;
    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;
    logic        cmd_ready_r;
    logic        busy_r;

    logic [15:0] poll_cnt_nxt_s;
    logic        hit_s;
    logic        rd_last_s;

    // Read-phase decode: next poll count, mask hit, and whether this is the sampling cycle
    always_comb begin
        poll_cnt_nxt_s = poll_cnt_r + 16'd1;
        hit_s          = ((rdata & data_hold_r) != 32'd0);
        if (RD_LATENCY == 0) begin
            rd_last_s = 1'b1;
        end else begin
            rd_last_s = lat_cnt_r;
        end
    end

    // Command sequencer with registered bus and response outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            is_poll_r   <= 1'b0;
            addr_hold_r <= 32'd0;
            data_hold_r <= 32'd0;
            poll_cnt_r  <= 16'd0;
            gap_cnt_r   <= 8'd0;
            lat_cnt_r   <= 1'b0;
            sel_r       <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_r) begin
                        addr_hold_r <= cmd_addr;
                        data_hold_r <= cmd_wdata;
                        is_poll_r   <= (cmd_op == 2'b10);
                        poll_cnt_r  <= 16'd0;
                        gap_cnt_r   <= 8'd0;
                        lat_cnt_r   <= 1'b0;
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        case (cmd_op)
                            2'b00: begin
                                state_r <= ST_WR;
                                sel_r   <= 1'b1;
                                we_r    <= 1'b1;
                                addr_r  <= cmd_addr;
                                wdata_r <= cmd_wdata;
                            end
                            2'b01, 2'b10: begin
                                state_r <= ST_RD;
                                sel_r   <= 1'b1;
                                we_r    <= 1'b0;
                                addr_r  <= cmd_addr;
                            end
                            default: begin
                                state_r     <= ST_RESP;
                                rsp_valid_r <= 1'b1;
                                rsp_rdata_r <= 32'd0;
                                rsp_err_r   <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_WR: begin
                    state_r     <= ST_RESP;
                    sel_r       <= 1'b0;
                    we_r        <= 1'b0;
                    addr_r      <= 32'd0;
                    wdata_r     <= 32'd0;
                    rsp_valid_r <= 1'b1;
                    rsp_rdata_r <= 32'd0;
                    rsp_err_r   <= 1'b0;
                end
                ST_RD: begin
                    if (!rd_last_s) begin
                        lat_cnt_r <= 1'b1;
                    end else begin
                        lat_cnt_r   <= 1'b0;
                        rsp_rdata_r <= rdata;
                        poll_cnt_r  <= poll_cnt_nxt_s;
                        // A mask hit wins even on the read that reaches the limit
                        if (!is_poll_r || hit_s || (poll_cnt_nxt_s == POLL_MAX_C)) begin
                            state_r     <= ST_RESP;
                            sel_r       <= 1'b0;
                            addr_r      <= 32'd0;
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= is_poll_r && !hit_s;
                        end else if (POLL_GAP == 0) begin
                            state_r <= ST_RD;
                        end else begin
                            state_r   <= ST_POLL_GAP;
                            sel_r     <= 1'b0;
                            addr_r    <= 32'd0;
                            gap_cnt_r <= 8'd0;
                        end
                    end
                end
                ST_POLL_GAP: begin
                    if (gap_cnt_r == GAP_LAST_C) begin
                        state_r <= ST_RD;
                        sel_r   <= 1'b1;
                        addr_r  <= addr_hold_r;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_r     <= ST_IDLE;
                        rsp_valid_r <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    sel_r       <= 1'b0;
                    we_r        <= 1'b0;
                    addr_r      <= 32'd0;
                    wdata_r     <= 32'd0;
                    rsp_valid_r <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign busy      = busy_r;
    assign sel       = sel_r;
    assign we        = we_r;
    assign addr      = addr_r;
    assign wdata     = wdata_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_vsd_bus_master.sv
// Directed bench for vsd_bus_master: two instances (RD_LATENCY 0/16/1 and 1/4/2)
// against a behavioural status-register stub, with hand-computed expectations.
module tb_vsd_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn_a    [2];
    logic        cmd_valid_a [2];
    logic        cmd_ready_a [2];
    logic [1:0]  cmd_op_a    [2];
    logic [31:0] cmd_addr_a  [2];
    logic [31:0] cmd_wdata_a [2];
    logic        rsp_valid_a [2];
    logic        rsp_ready_a [2];
    logic [31:0] rsp_rdata_a [2];
    logic        rsp_err_a   [2];
    logic        sel_a       [2];
    logic        we_a        [2];
    logic [31:0] addr_a      [2];
    logic [31:0] wdata_a     [2];
    logic [31:0] rdata_a     [2];
    logic        busy_a      [2];

    vsd_bus_master #(.RD_LATENCY(0), .POLL_MAX(16), .POLL_GAP(1)) dut0 (
        .clk(clk), .resetn(resetn_a[0]), .cmd_valid(cmd_valid_a[0]), .cmd_ready(cmd_ready_a[0]),
        .cmd_op(cmd_op_a[0]), .cmd_addr(cmd_addr_a[0]), .cmd_wdata(cmd_wdata_a[0]),
        .rsp_valid(rsp_valid_a[0]), .rsp_ready(rsp_ready_a[0]), .rsp_rdata(rsp_rdata_a[0]),
        .rsp_err(rsp_err_a[0]), .sel(sel_a[0]), .we(we_a[0]), .addr(addr_a[0]),
        .wdata(wdata_a[0]), .rdata(rdata_a[0]), .busy(busy_a[0])
    );

    vsd_bus_master #(.RD_LATENCY(1), .POLL_MAX(4), .POLL_GAP(2)) dut1 (
        .clk(clk), .resetn(resetn_a[1]), .cmd_valid(cmd_valid_a[1]), .cmd_ready(cmd_ready_a[1]),
        .cmd_op(cmd_op_a[1]), .cmd_addr(cmd_addr_a[1]), .cmd_wdata(cmd_wdata_a[1]),
        .rsp_valid(rsp_valid_a[1]), .rsp_ready(rsp_ready_a[1]), .rsp_rdata(rsp_rdata_a[1]),
        .rsp_err(rsp_err_a[1]), .sel(sel_a[1]), .we(we_a[1]), .addr(addr_a[1]),
        .wdata(wdata_a[1]), .rdata(rdata_a[1]), .busy(busy_a[1])
    );

    int n_vec  = 0;
    int n_miss = 0;

    int          sel_rises  [2] = '{0, 0};
    int          sel_cycles [2] = '{0, 0};
    int          wr_cycles  [2] = '{0, 0};
    int          gap_run    [2] = '{0, 0};
    int          last_gap   [2] = '{0, 0};
    int          idle_bad   [2] = '{0, 0};
    logic        sel_q      [2] = '{1'b0, 1'b0};
    logic [31:0] last_waddr [2] = '{32'd0, 32'd0};
    logic [31:0] last_wdata [2] = '{32'd0, 32'd0};
    int          poll_base  [2] = '{0, 0};
    int          set_at     [2] = '{0, 0};

    // Bus monitor, sampled mid-cycle: counts accesses, gap lengths and idle-bus violations
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (sel_a[d] === 1'b1) begin
                sel_cycles[d] = sel_cycles[d] + 1;
                if (sel_q[d] !== 1'b1) begin
                    sel_rises[d] = sel_rises[d] + 1;
                    last_gap[d]  = gap_run[d];
                end
                if (we_a[d] === 1'b1) begin
                    wr_cycles[d]  = wr_cycles[d] + 1;
                    last_waddr[d] = addr_a[d];
                    last_wdata[d] = wdata_a[d];
                end
                gap_run[d] = 0;
            end else begin
                if (we_a[d] !== 1'b0 || addr_a[d] !== 32'd0 || wdata_a[d] !== 32'd0)
                    idle_bad[d] = idle_bad[d] + 1;
                gap_run[d] = gap_run[d] + 1;
            end
            sel_q[d] = sel_a[d];
        end
    end

    // Peripheral stub: 0x08 reads 7; 0x0C is a status register whose bit0 sets on read set_at
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            int n;
            n = sel_rises[d] - poll_base[d];
            if (addr_a[d] == 32'h0000_0008)
                rdata_a[d] = 32'h0000_0007;
            else if (addr_a[d] == 32'h0000_000C)
                rdata_a[d] = (set_at[d] != 0 && n >= set_at[d]) ? 32'h0000_0001
                                                                  : (32'hA500_0000 | (32'(n) << 4));
            else
                rdata_a[d] = 32'hDEAD_0000;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input int d, input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd);
        int t = 0;
        while (cmd_ready_a[d] !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready_a[d]), 32'd1);
        cmd_valid_a[d] = 1'b1;
        cmd_op_a[d]    = op;
        cmd_addr_a[d]  = a;
        cmd_wdata_a[d] = wd;
        @(posedge clk);
        @(negedge clk);
        cmd_valid_a[d] = 1'b0;
    endtask

    task automatic wait_rsp(input int d, output int lat);
        lat = 1;
        while (rsp_valid_a[d] !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_rsp(input int d, input int stall, output logic [31:0] rd, output logic err);
        int bad = 0;
        rd  = rsp_rdata_a[d];
        err = rsp_err_a[d];
        for (int i = 0; i < stall; i++) begin
            if (rsp_valid_a[d] !== 1'b1 || rsp_rdata_a[d] !== rd || rsp_err_a[d] !== err
                || cmd_ready_a[d] !== 1'b0)
                bad++;
            @(negedge clk);
        end
        if (stall > 0) chk("stall_stable", 32'(bad), 32'd0);
        rsp_ready_a[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready_a[d] = 1'b0;
        chk("rsp_drop", 32'(rsp_valid_a[d]), 32'd0);
        chk("ready_back", 32'(cmd_ready_a[d]), 32'd1);
    endtask

    task automatic run(input int d, input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input int stall, output int lat, output logic [31:0] rd, output logic err);
        issue(d, op, a, wd);
        wait_rsp(d, lat);
        take_rsp(d, stall, rd, err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat, s0, c0, w0, cnt;
        logic [31:0] rd;
        logic        err;
        logic        prev;

        for (int d = 0; d < 2; d++) begin
            resetn_a[d]    = 1'b0;
            cmd_valid_a[d] = 1'b0;
            cmd_op_a[d]    = 2'b00;
            cmd_addr_a[d]  = 32'd0;
            cmd_wdata_a[d] = 32'd0;
            rsp_ready_a[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        resetn_a[0] = 1'b1;
        resetn_a[1] = 1'b1;
        @(negedge clk);

        chk("rst_cmd_ready", 32'(cmd_ready_a[0]), 32'd1);
        chk("rst_sel", 32'(sel_a[0]), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_a[0]), 32'd0);
        chk("rst_busy", 32'(busy_a[0]), 32'd0);
        chk("rst_addr", addr_a[0], 32'd0);
        chk("rst_rdata", rsp_rdata_a[0], 32'd0);

        // Write 0x04 <- 10
        s0 = sel_cycles[0]; w0 = wr_cycles[0];
        run(0, 2'b00, 32'h04, 32'd10, 0, lat, rd, err);
        chk("wr_lat", 32'(lat), 32'd2);
        chk("wr_rdata", rd, 32'd0);
        chk("wr_err", 32'(err), 32'd0);
        chk("wr_cycles", 32'(wr_cycles[0] - w0), 32'd1);
        chk("wr_sel_cycles", 32'(sel_cycles[0] - s0), 32'd1);
        chk("wr_addr", last_waddr[0], 32'h04);
        chk("wr_wdata", last_wdata[0], 32'd10);

        // Read 0x08, RD_LATENCY 0 and 1
        s0 = sel_cycles[0]; w0 = wr_cycles[0];
        run(0, 2'b01, 32'h08, 32'hFFFF_FFFF, 0, lat, rd, err);
        chk("rd0_lat", 32'(lat), 32'd2);
        chk("rd0_rdata", rd, 32'h7);
        chk("rd0_err", 32'(err), 32'd0);
        chk("rd0_sel_cycles", 32'(sel_cycles[0] - s0), 32'd1);
        chk("rd0_no_write", 32'(wr_cycles[0] - w0), 32'd0);

        s0 = sel_cycles[1];
        run(1, 2'b01, 32'h08, 32'd0, 0, lat, rd, err);
        chk("rd1_lat", 32'(lat), 32'd3);
        chk("rd1_rdata", rd, 32'h7);
        chk("rd1_sel_cycles", 32'(sel_cycles[1] - s0), 32'd2);

        // Poll: status bit sets on 5th read, gap 1
        poll_base[0] = sel_rises[0]; set_at[0] = 5; s0 = sel_cycles[0];
        run(0, 2'b10, 32'h0C, 32'h1, 0, lat, rd, err);
        chk("poll5_reads", 32'(sel_rises[0] - poll_base[0]), 32'd5);
        chk("poll5_sel_cycles", 32'(sel_cycles[0] - s0), 32'd5);
        chk("poll5_gap", 32'(last_gap[0]), 32'd1);
        chk("poll5_lat", 32'(lat), 32'd10);
        chk("poll5_rdata", rd, 32'h1);
        chk("poll5_err", 32'(err), 32'd0);

        // Poll limit 4, never set, RD_LATENCY 1, gap 2
        poll_base[1] = sel_rises[1]; set_at[1] = 0; s0 = sel_cycles[1];
        run(1, 2'b10, 32'h0C, 32'h1, 0, lat, rd, err);
        chk("plim_reads", 32'(sel_rises[1] - poll_base[1]), 32'd4);
        chk("plim_sel_cycles", 32'(sel_cycles[1] - s0), 32'd8);
        chk("plim_gap", 32'(last_gap[1]), 32'd2);
        chk("plim_lat", 32'(lat), 32'd15);
        chk("plim_rdata", rd, 32'hA500_0040);
        chk("plim_err", 32'(err), 32'd1);

        // Success on the very read that hits the limit
        poll_base[1] = sel_rises[1]; set_at[1] = 4;
        run(1, 2'b10, 32'h0C, 32'h1, 0, lat, rd, err);
        chk("pedge_reads", 32'(sel_rises[1] - poll_base[1]), 32'd4);
        chk("pedge_rdata", rd, 32'h1);
        chk("pedge_err", 32'(err), 32'd0);

        // Mask 0 never succeeds: full 16 reads
        poll_base[0] = sel_rises[0]; set_at[0] = 1;
        run(0, 2'b10, 32'h0C, 32'h0, 0, lat, rd, err);
        chk("pmask0_reads", 32'(sel_rises[0] - poll_base[0]), 32'd16);
        chk("pmask0_lat", 32'(lat), 32'd32);
        chk("pmask0_rdata", rd, 32'h1);
        chk("pmask0_err", 32'(err), 32'd1);

        // Illegal op
        s0 = sel_rises[0];
        run(0, 2'b11, 32'h08, 32'h5, 0, lat, rd, err);
        chk("ill_lat", 32'(lat), 32'd1);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_rdata", rd, 32'd0);
        chk("ill_no_sel", 32'(sel_rises[0] - s0), 32'd0);

        // Response back-pressure for 10 cycles
        run(0, 2'b01, 32'h08, 32'd0, 10, lat, rd, err);
        chk("stall_rdata", rd, 32'h7);
        chk("stall_err", 32'(err), 32'd0);

        // Reset during the 3rd poll read
        poll_base[0] = sel_rises[0]; set_at[0] = 0;
        issue(0, 2'b10, 32'h0C, 32'h1);
        cnt = 0; prev = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (sel_a[0] === 1'b1 && prev !== 1'b1) cnt++;
            prev = sel_a[0];
            if (cnt == 3) break;
            @(negedge clk);
        end
        chk("rstmid_reached", 32'(cnt), 32'd3);
        resetn_a[0] = 1'b0;
        @(negedge clk);
        chk("rstmid_sel", 32'(sel_a[0]), 32'd0);
        chk("rstmid_rsp_valid", 32'(rsp_valid_a[0]), 32'd0);
        chk("rstmid_busy", 32'(busy_a[0]), 32'd0);
        resetn_a[0] = 1'b1;
        @(negedge clk);
        chk("rstmid_rsp_valid2", 32'(rsp_valid_a[0]), 32'd0);
        w0 = wr_cycles[0];
        run(0, 2'b00, 32'h10, 32'h55, 0, lat, rd, err);
        chk("post_wr_lat", 32'(lat), 32'd2);
        chk("post_wr_err", 32'(err), 32'd0);
        chk("post_wr_cycles", 32'(wr_cycles[0] - w0), 32'd1);
        chk("post_wr_wdata", last_wdata[0], 32'h55);

        chk("idle_bus0", 32'(idle_bad[0]), 32'd0);
        chk("idle_bus1", 32'(idle_bad[1]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/vsd_bus_master.md
Name: vsd_bus_master

Overview:
Bus initiator for the VSD peripheral bus (sel/we/addr/wdata/rdata). It drives the same single-cycle request protocol that the timer IP responds to. It accepts write, read and poll commands from a core-side valid/ready command port, runs them one at a time on the bus, and returns results on a valid/ready response port. Poll repeatedly reads a status register until a masked bit is set or a retry limit is reached. Its intended use is to program and supervise the timer without CPU involvement.

Parameters:
RD_LATENCY, 0, extra cycles sel/addr stay asserted before rdata is sampled (0 or 1 supported).
POLL_MAX, 16, maximum number of bus reads per poll command (1..65535).
POLL_GAP, 1, idle cycles (sel=0) between successive poll reads (0..255).

Ports:
clk  input  1  system clock, all logic on rising edge.
resetn  input  1  synchronous, active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  block can accept a command.
cmd_op  input  2  00=write, 01=read, 10=poll, 11=illegal.
cmd_addr  input  32  target bus address.
cmd_wdata  input  32  write data (write); bit mask (poll); ignored (read).
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts response.
rsp_rdata  output  32  read data / last polled value; 0 for write.
rsp_err  output  1  poll limit reached or illegal op.
sel  output  1  bus select.
we  output  1  bus write enable.
addr  output  32  bus address.
wdata  output  32  bus write data.
rdata  input  32  bus read data from the selected peripheral.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: clk and resetn only; reset is synchronous, active-low. State=IDLE. sel=we=0; addr=wdata=0; rsp_valid=0; rsp_rdata=0; rsp_err=0; poll counter=0; cmd_ready=1 on the first cycle after reset is released.
- All bus outputs are registered. When no access is in progress, sel=we=0 and addr=wdata=0.
- cmd_ready is high only in IDLE. A command is accepted on a cycle with cmd_valid&&cmd_ready, and its fields are latched on that cycle.
- States: IDLE, WR, RD, POLL_GAP, RESP.
- IDLE, accept, then:
  - op 00 -> WR
  - op 01 or 10 -> RD (poll counter cleared)
  - op 11 -> RESP directly with rsp_err=1 and rsp_rdata=0; no bus cycle is issued.
- WR: exactly one cycle with sel=1, we=1, addr, wdata. Next state is RESP with rsp_rdata=0, rsp_err=0.
- RD:
  - sel=1, we=0, addr held for 1+RD_LATENCY cycles.
  - rdata is sampled at the rising edge that ends the last of those cycles. The sampled value goes to rsp_rdata.
  - Read op: next state is RESP, rsp_err=0.
  - Poll op, counter increments on every read:
    - (rdata & mask)!=0 -> RESP, rsp_err=0 (success takes priority if it coincides with hitting the limit).
    - else if counter==POLL_MAX -> RESP, rsp_err=1, rsp_rdata=last value.
    - else -> POLL_GAP, or straight back to RD if POLL_GAP=0.
- POLL_GAP: sel=0 and addr=0 for POLL_GAP cycles, then RD.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_ready.
  - On the cycle with rsp_valid&&rsp_ready -> IDLE, rsp_valid=0 the next cycle. The next command can be accepted on the cycle after that.
  - A command cannot be accepted in the same cycle as a response handshake.
- Latency, command accept to rsp_valid (RD_LATENCY=0): write 2 cycles, read 2 cycles, illegal op 1 cycle.
- Mask = 0 on a poll: never succeeds, so the poll ends with rsp_err=1 after POLL_MAX reads.
- Reset asserted mid-operation: on that edge sel is dropped, the command is discarded with no response, and the block returns to the reset state.
- Address/data are passed through unmodified. There is no alignment checking.

Test Plan:
- cmd write addr=0x04 data=10 -> exactly one bus cycle sel=1 we=1 addr=0x04 wdata=10. rsp_valid 2 cycles after accept with rsp_rdata=0, rsp_err=0.
- cmd read addr=0x08, stub returns 0x7 -> one cycle sel=1 we=0 addr=0x08; rsp_rdata=0x7, rsp_err=0. Repeat with RD_LATENCY=1: sel held 2 cycles, same result.
- cmd poll addr=0x0C mask=0x1, stub STATUS bit0 sets on the 5th read (POLL_GAP=1) -> 5 read cycles, each separated by 1 idle cycle; rsp_rdata=0x1, rsp_err=0.
- POLL_MAX=4, poll with the status bit never set -> exactly 4 reads, then rsp_err=1 and rsp_rdata = last value read. Illegal op 11 -> rsp_err=1 after 1 cycle, no sel pulse.
- rsp_ready held low 10 cycles after a read -> rsp_valid and rsp_rdata stable the whole time, cmd_ready=0 throughout; command accepted only after the handshake.
- resetn pulled low during the 3rd poll read -> sel=0 and rsp_valid=0 the next cycle, busy=0; a fresh write afterwards completes normally.
